// File: rtl/imem_responder.sv
// imem_responder: multi-cycle instruction-memory responder for the fetch stage.
// A read is held for LATENCY cycles (Stall high while counting), then one word
// is returned with a one-cycle Done strobe. A single-cycle write port preloads
// the array when the block is not stalled and no read is being requested.
// Optional feature macro: IMEM_ALIGN_CHECK_EN. When it is defined, an odd byte
// address returns a NOP word and raises Err in the Done cycle.
module imem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [15:0] NOP    = 16'h0800;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [15:0]         r_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   w_idx;
  logic [ADDR_W-1:0]   w_cap_idx;
  logic                w_accept;
  logic                w_wr;
  logic                w_fin;
  logic                w_cap;

  // Byte address to word index; Addr[0] and bits above ADDR_W never select data.
  assign w_idx     = Addr[ADDR_W:1];
  assign w_accept  = Rd && (r_state != S_WAIT);
  assign w_wr      = Wr && !Rd && (r_state != S_WAIT);
  // Countdown reaches zero on this edge.
  assign w_fin     = (r_state == S_WAIT) && (r_cnt == 4'd1);
  // With LATENCY==1 the word is captured on the acceptance edge itself.
  assign w_cap     = w_fin || (w_accept && (LATENCY == 1));
  assign w_cap_idx = (r_state == S_WAIT) ? r_idx : w_idx;

  if (ADDR_W < 15) begin : g_hi_addr
    logic w_unused_hi;
    assign w_unused_hi = ^Addr[15:ADDR_W+1];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic; RESP behaves like IDLE so reads can run back to back.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (Rd)                     w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        else                        w_next = S_IDLE;
      end
      S_WAIT:  if (r_cnt == 4'd1)   w_next = S_RESP;
      default:                      w_next = S_IDLE;
    endcase
  end

  // FSM outputs: pure state decodes, no path from Rd/Addr.
  always_comb begin
    Stall = (r_state == S_WAIT);
    Done  = (r_state == S_RESP);
  end

  // Request latch and latency countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_cnt <= LAT_M1;
      r_idx <= w_idx;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Preload write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= DataIn;
  end

`ifdef IMEM_ALIGN_CHECK_EN
  logic r_mis;
  logic w_cap_mis;
  logic r_err;

  assign w_cap_mis = (r_state == S_WAIT) ? r_mis : Addr[0];

  // Remember whether the accepted request was misaligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_mis <= 1'b0;
    else if (w_accept) r_mis <= Addr[0];
  end

  // Response word: NOP for a misaligned request, array data otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DataOut <= 16'h0000;
      r_err   <= 1'b0;
    end else if (w_cap) begin
      DataOut <= w_cap_mis ? NOP : r_mem[w_cap_idx];
      r_err   <= w_cap_mis;
    end
  end

  assign Err = r_err;
`else
  logic w_unused_a0;
  logic w_unused_nop;
  assign w_unused_a0  = Addr[0];
  assign w_unused_nop = ^NOP;

  // Response word captured as the countdown expires; held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       DataOut <= 16'h0000;
    else if (w_cap) DataOut <= r_mem[w_cap_idx];
  end

  assign Err = 1'b0;
`endif

endmodule

// File: doc/imem_responder.md
# imem_responder

Multi-cycle instruction-memory responder: the memory side of the fetch-stage instruction read. It accepts a read request from the fetch stage, holds it for a fixed number of cycles and returns one 16-bit instruction word with a `Done` strobe. While a request is pending it asserts `Stall`, and the fetch/hazard logic freezes the PC on `Stall`. A single-cycle write port preloads program images from the loader or testbench.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; the array holds 2^ADDR_W 16-bit words.
- `LATENCY`, default 4: cycles from request acceptance to `Done`; legal range 1..15.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `Addr`  in  16: byte address.
- `Rd`  in  1: read request.
- `Wr`  in  1: preload write request.
- `DataIn`  in  16: write data.
- `DataOut`  out  16: registered instruction word.
- `Done`  out  1: one-cycle strobe; `DataOut` is valid in this cycle.
- `Stall`  out  1: a request presented in this cycle is not accepted.
- `Err`  out  1: misaligned-read flag, qualified by `Done`; tied to 0 when the alignment-check feature is compiled out.

## Operation
- Word index is `Addr[ADDR_W:1]`.
  - `Addr[0]` does not select data.
  - Bits above `ADDR_W` are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- States:
  - IDLE: nothing pending.
  - WAIT: counting down.
  - RESP: `Done` cycle.
- Request acceptance:
  - `Rd` is accepted when state is IDLE or RESP, which gives `Stall`=0.
  - On acceptance, latch the word index and load a 4-bit counter with `LATENCY`-1.
- State transitions:
  - Accepted `Rd` with `LATENCY`=1: go directly to RESP.
  - Accepted `Rd` otherwise: go to WAIT.
  - In WAIT, decrement the counter each cycle. When the counter reaches 0, capture `mem[latched index]` into `DataOut` and enter RESP.
  - From RESP: a new accepted `Rd` behaves as it does from IDLE (back-to-back reads). Otherwise go to IDLE.
- Output behaviour:
  - `Stall` = (state==WAIT).
  - `Done` = (state==RESP).
  - `DataOut` holds its last value until the next RESP entry.
- Writes:
  - `Wr` is accepted only when `Stall`=0 and `Rd`=0. It writes `mem[Addr[ADDR_W:1]] <= DataIn` at the edge and produces no `Done`.
  - `Rd` and `Wr` asserted together: the read wins and the write is dropped.
  - `Wr` in WAIT is dropped.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the new data.
- Memory contents are not reset. Uninitialised words read as X in simulation.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - `DataOut`=16'h0000.
  - `Done`=0, `Stall`=0, `Err`=0.
- Read latency: a `Rd` accepted at edge t gives `Done`=1 for exactly the cycle after edge t+`LATENCY`-1.
- `Stall` is high for `LATENCY`-1 cycles per request.
- Throughput: one read per `LATENCY` cycles, with no idle cycle between back-to-back reads.
- `Stall` and `Done` are purely registered-state decodes. They carry no combinational path from `Rd`/`Addr`.
- Reset asserted mid-request: the request is aborted and no `Done` is issued. After release the block is in IDLE and accepts `Rd` on the first edge.

## Configuration
- Macro: `IMEM_ALIGN_CHECK_EN`.
- Defined:
  - An accepted `Rd` with `Addr[0]`=1 still takes the full `LATENCY`.
  - In its `Done` cycle, `Err`=1 and `DataOut`=16'h0800 (NOP) instead of array data.
  - `Err` clears on the next non-erroring RESP or on reset.
- Undefined:
  - `Addr[0]` is ignored and `Err` is constant 0.
  - No NOP substitution; the array word is returned.

## Test plan
- Reset → state: with `rst` low, hold `Rd`=1. Required: `Stall`=0, `Done`=0, `DataOut`=0x0000. After release, the first `Rd` is accepted.
- Preload then single read: with `LATENCY`=4, `Wr` 0xA5C3 to `Addr`=0x0010, then `Rd` at 0x0010. Required: `Stall`=1 for 3 cycles, then `Done`=1 for 1 cycle with `DataOut`=0xA5C3.
- Back-to-back reads: `Rd` at 0x0000, then `Rd` held through the RESP cycle at 0x0002 (words 0x1111 and 0x2222). Required: a `Done` every 4 cycles, returning 0x1111 then 0x2222, with no IDLE cycle between them.
- Contention: `Rd`+`Wr` asserted together at 0x0004, writing 0xFFFF onto stored value 0x0123. Required: the read returns 0x0123 and a later read also returns 0x0123. `Wr` during WAIT leaves the target word unchanged.
- Wrap and mid-request reset: with `ADDR_W`=10, `Rd` at 0x0806 returns word 3. Dropping `rst` at WAIT cycle 2 gives no `Done`, and `Stall`=0 immediately.
- Alignment (macro defined): `Rd` at 0x0011. Required: `Done` with `Err`=1 and `DataOut`=0x0800. With the macro undefined, the same request returns word 8 with `Err`=0.
